muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit plus HI/LO register file for the pipelined MIPS core.
- Sits beside the EX-stage ALU. Accepts mult/multu/div/divu from EX, plus mthi/mtlo writes.
- Runs a 32-step shift-add multiply or restoring divide over multiple cycles.
- Raises a stall to the hazard logic while later instructions need HI/LO or the unit.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_datapath.sv | 75 +++++++
 rtl/muldiv_sequencer.sv | 92 +++++++++
 tb/tb_muldiv_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes mirror Funct[1:0] of mult/multu/div/divu.
package muldiv_pkg;
    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldivState;
endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv unit bundle: issue, HI/LO moves, and stall/status back.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             kill;
    logic             mt_we;
    logic             mt_sel;
    logic [WIDTH-1:0] mt_data;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, kill, mt_we, mt_sel, mt_data, mf_req,
                    input  busy, stall, done, hi, lo);
    modport slave  (input  start, op, src_a, src_b, kill, mt_we, mt_sel, mt_data, mf_req,
                    output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_datapath.sv
// 2*WIDTH accumulator with one shift-add / restoring-divide step per cycle,
// plus the combinational sign fixup that produces the HI/LO write values.
module muldiv_datapath import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] resHi,
    output logic [WIDTH-1:0] resLo
);
    logic [2*WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0]   operand, absA, absB;
    logic               isDiv, divZero, negQ, negR;
    logic               aNeg, bNeg;
    logic [WIDTH:0]     mulSum, divTop, divDiff;
    logic               divGe;

    assign aNeg = ~op[0] & srcA[WIDTH-1];
    assign bNeg = ~op[0] & srcB[WIDTH-1];
    assign absA = aNeg ? -srcA : srcA;
    assign absB = bNeg ? -srcB : srcB;

    // Multiply: add operand into the upper half, shift right with carry.
    // Divide: shift left, compare the W+1-bit top against the divisor.
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign divTop  = acc[2*WIDTH-1:WIDTH-1];
    assign divGe   = divTop >= {1'b0, operand};
    assign divDiff = divTop - {1'b0, operand};

    always_comb begin
        accNext = {mulSum, acc[WIDTH-1:1]};
        if (isDiv)
            accNext = {(divGe ? divDiff[WIDTH-1:0] : divTop[WIDTH-1:0]), acc[WIDTH-2:0], divGe};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            divZero <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
        end else if (load) begin
            divZero <= op[1] && (srcB == '0);
            // Divide-by-zero keeps the raw dividend; it lands in HI untouched.
            acc     <= {{WIDTH{1'b0}}, (op[1] && (srcB == '0)) ? srcA : absA};
            operand <= absB;
            isDiv   <= op[1];
            negQ    <= aNeg ^ bNeg;
            negR    <= aNeg;
        end else if (step) begin
            acc <= accNext;
        end
    end

    always_comb begin
        resHi = acc[2*WIDTH-1:WIDTH];
        resLo = acc[WIDTH-1:0];
        if (divZero) begin
            resHi = acc[WIDTH-1:0];
            resLo = '1;
        end else if (isDiv) begin
            if (negQ) resLo = -acc[WIDTH-1:0];
            if (negR) resHi = -acc[2*WIDTH-1:WIDTH];
        end else if (negQ) begin
            {resHi, resLo} = -acc;
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer: FSM, iteration counter, HI/LO registers
// and the stall request to the hazard unit.
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    muldivState       state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hiReg, loReg, resHi, resLo;
    logic             accept, step, resWe, mtWe, busyInt, divZero;

    assign divZero = bus.op[1] && (bus.src_b == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        step      = 1'b0;
        resWe     = 1'b0;
        case (state)
            IDLE, DONE: begin
                stateNext = IDLE;
                if (bus.start && !bus.kill) begin
                    accept    = 1'b1;
                    stateNext = divZero ? FIX : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (bus.kill)                     stateNext = IDLE;
                else if (cnt == CNT_W'(WIDTH-1)) stateNext = FIX;
            end
            FIX: begin
                if (bus.kill) stateNext = IDLE;
                else begin
                    resWe     = 1'b1;
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busyInt = (state == CALC) || (state == FIX);
    // A start accepted in the same cycle takes priority over a HI/LO move.
    assign mtWe    = bus.mt_we && !busyInt && !accept;

    always_ff @(posedge clk) begin
        if (reset)              cnt <= '0;
        else if (accept)        cnt <= '0;
        else if (state == CALC) cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (resWe) begin
            hiReg <= resHi;
            loReg <= resLo;
        end else if (mtWe) begin
            if (bus.mt_sel) hiReg <= bus.mt_data;
            else            loReg <= bus.mt_data;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) datapath (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (step),
        .op    (bus.op),
        .srcA  (bus.src_a),
        .srcB  (bus.src_b),
        .resHi (resHi),
        .resLo (resLo)
    );

    assign bus.busy  = busyInt;
    assign bus.stall = busyInt & (bus.start | bus.mf_req | bus.mt_we);
    assign bus.done  = (state == DONE);
    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench: table of mult/div vectors with hand-computed HI/LO and
// latency, then hand-written stall/kill/reset/move sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vecT;

    logic clk = 1'b0;
    logic reset;
    int   nVec = 0;
    int   nErr = 0;

    muldiv_if #(.WIDTH(32)) ifc ();

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op in cycle 0; return when done is seen (or bound expires).
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyCycles);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = o; ifc.src_a = a; ifc.src_b = b;
        @(negedge clk);
        ifc.start = 1'b0;
        lat = 1; busyCycles = 0;
        while (!ifc.done && lat < 100) begin
            if (ifc.busy) busyCycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    vecT vecs[12];
    int  lat, bc, n;
    logic [31:0] prevLo, prevHi;

    initial begin
        vecs[0]  = '{OP_MULTU, 32'd7,         32'd6,         32'h00000000, 32'h0000002A, 34};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1, 34};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3]  = '{OP_DIVU,  32'h12345678,  32'd0,         32'h12345678, 32'hFFFFFFFF, 2};
        vecs[4]  = '{OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000, 34};
        vecs[5]  = '{OP_MULTU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 34};
        vecs[6]  = '{OP_MULT,  32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000, 34};
        vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'h00000002, 32'h0000000E, 34};
        vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFFFFFE,  32'h00000001, 32'hFFFFFFFD, 34};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9, 32'hFFFFFFFF, 2};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF,  32'd1,         32'h00000000, 32'hFFFFFFFF, 34};
        vecs[11] = '{OP_MULT,  32'h7FFFFFFF,  32'd2,         32'h00000000, 32'hFFFFFFFE, 34};

        ifc.start = 1'b0; ifc.op = 2'b00; ifc.src_a = '0; ifc.src_b = '0;
        ifc.kill = 1'b0; ifc.mt_we = 1'b0; ifc.mt_sel = 1'b0; ifc.mt_data = '0;
        ifc.mf_req = 1'b0;
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        #1;
        chk("reset.busy",  32'(ifc.busy),  32'd0);
        chk("reset.stall", 32'(ifc.stall), 32'd0);
        chk("reset.done",  32'(ifc.done),  32'd0);
        chk("reset.hi",    ifc.hi, 32'd0);
        chk("reset.lo",    ifc.lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].expLat));
            chk($sformatf("vec%0d.busyCycles", i), 32'(bc), 32'(vecs[i].expLat - 1));
            chk($sformatf("vec%0d.hi", i), ifc.hi, vecs[i].expHi);
            chk($sformatf("vec%0d.lo", i), ifc.lo, vecs[i].expLo);
            @(negedge clk);
            chk($sformatf("vec%0d.doneOnce", i), 32'(ifc.done), 32'd0);
        end

        // mf_req held from cycle 2 stalls through the last busy cycle only.
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = OP_MULT; ifc.src_a = 32'd3; ifc.src_b = 32'd4;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        ifc.mf_req = 1'b1;
        n = 0;
        for (int c = 2; c <= 33; c++) begin
            #1;
            if (ifc.stall) n++;
            @(negedge clk);
        end
        #1;
        chk("mf.stallCycles", 32'(n), 32'd32);
        chk("mf.doneCycle",   32'(ifc.done),  32'd1);
        chk("mf.stallInDone", 32'(ifc.stall), 32'd0);
        chk("mf.lo",          ifc.lo, 32'd12);
        ifc.mf_req = 1'b0;
        @(negedge clk);

        // mt_we while busy is ignored until re-presented after the op.
        prevLo = ifc.lo;
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = OP_MULTU; ifc.src_a = 32'd2; ifc.src_b = 32'd3;
        @(negedge clk);
        ifc.start = 1'b0;
        waitCycles(4);
        ifc.mt_we = 1'b1; ifc.mt_sel = 1'b0; ifc.mt_data = 32'h11111111;
        #1;
        chk("mtBusy.stall", 32'(ifc.stall), 32'd1);
        @(negedge clk);
        chk("mtBusy.loHeld", ifc.lo, prevLo);
        ifc.mt_we = 1'b0;
        n = 0;
        while (!ifc.done && n < 100) begin @(negedge clk); n++; end
        chk("mtBusy.result", ifc.lo, 32'd6);
        @(negedge clk);
        ifc.mt_we = 1'b1;
        @(negedge clk);
        ifc.mt_we = 1'b0;
        chk("mtBusy.represented", ifc.lo, 32'h11111111);

        // Idle moves.
        ifc.mt_we = 1'b1; ifc.mt_sel = 1'b0; ifc.mt_data = 32'hCAFEBABE;
        @(negedge clk);
        ifc.mt_sel = 1'b1; ifc.mt_data = 32'h0BADF00D;
        chk("mtlo", ifc.lo, 32'hCAFEBABE);
        @(negedge clk);
        ifc.mt_we = 1'b0;
        chk("mthi", ifc.hi, 32'h0BADF00D);

        // kill at cycle 10 of a div.
        ifc.start = 1'b1; ifc.op = OP_DIVU; ifc.src_a = 32'd100; ifc.src_b = 32'd7;
        @(negedge clk);
        ifc.start = 1'b0;
        waitCycles(9);
        ifc.kill = 1'b1;
        @(negedge clk);
        ifc.kill = 1'b0;
        chk("kill.busy", 32'(ifc.busy), 32'd0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (ifc.done) n++;
            @(negedge clk);
        end
        chk("kill.noDone", 32'(n), 32'd0);
        chk("kill.hi", ifc.hi, 32'h0BADF00D);
        chk("kill.lo", ifc.lo, 32'hCAFEBABE);

        // kill and start together in IDLE: start is dropped.
        ifc.start = 1'b1; ifc.kill = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0; ifc.kill = 1'b0;
        chk("killStart.busy", 32'(ifc.busy), 32'd0);

        // Reset at cycle 15 of a mult.
        ifc.start = 1'b1; ifc.op = OP_MULT; ifc.src_a = 32'd5; ifc.src_b = 32'd5;
        @(negedge clk);
        ifc.start = 1'b0;
        waitCycles(14);
        chk("rstMid.busyBefore", 32'(ifc.busy), 32'd1);
        reset = 1'b1; ifc.mf_req = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstMid.busy",  32'(ifc.busy),  32'd0);
        chk("rstMid.stall", 32'(ifc.stall), 32'd0);
        chk("rstMid.hi",    ifc.hi, 32'd0);
        chk("rstMid.lo",    ifc.lo, 32'd0);
        ifc.mf_req = 1'b0;
        waitCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
